// File: rtl/mdu_iterative.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready handshakes on both sides.
module mdu_iterative #(
    parameter  int XLEN  = 64,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      mdu_ctrl,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        op_reg;
    logic [XLEN-1:0]   opnd_reg;
    logic [XLEN-1:0]   acc_hi_reg;
    logic [XLEN-1:0]   acc_lo_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              neg_q_reg;
    logic              neg_r_reg;
    logic              special_reg;
    logic [XLEN-1:0]   result_reg;
    logic              zero_reg;

    // Operand decode at the handshake
    logic            is_div_in, a_signed_in, b_signed_in, a_neg_in, b_neg_in;
    logic [XLEN-1:0] a_mag_in, b_mag_in, special_val_in;
    logic            div_zero_in, ovf_in, special_in;

    always_comb begin
        is_div_in      = mdu_ctrl[2];
        a_signed_in    = (mdu_ctrl == OP_MULH) || (mdu_ctrl == OP_MULHSU) ||
                         (mdu_ctrl == OP_DIV)  || (mdu_ctrl == OP_REM);
        b_signed_in    = (mdu_ctrl == OP_MULH) || (mdu_ctrl == OP_DIV) || (mdu_ctrl == OP_REM);
        a_neg_in       = a_signed_in && rs1_data[XLEN-1];
        b_neg_in       = b_signed_in && rs2_data[XLEN-1];
        // Negating min-int yields 2^(XLEN-1), which is the correct unsigned magnitude
        a_mag_in       = a_neg_in ? (~rs1_data + 1'b1) : rs1_data;
        b_mag_in       = b_neg_in ? (~rs2_data + 1'b1) : rs2_data;
        div_zero_in    = is_div_in && (rs2_data == '0);
        ovf_in         = is_div_in && !mdu_ctrl[0] && (rs1_data == MIN_INT) && (rs2_data == '1);
        special_in     = div_zero_in || ovf_in;
        special_val_in = '0;
        if (div_zero_in)
            special_val_in = mdu_ctrl[1] ? rs1_data : '1;
        else if (ovf_in)
            special_val_in = mdu_ctrl[1] ? '0 : MIN_INT;
    end

    // One iteration step; acc_hi/acc_lo hold partial product or remainder/quotient
    logic [XLEN:0]   mul_sum, div_shift, div_trial;
    logic            div_ok;
    logic [XLEN-1:0] step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
        div_shift = {acc_hi_reg, acc_lo_reg[XLEN-1]};
        div_trial = div_shift - {1'b0, opnd_reg};
        div_ok    = !div_trial[XLEN];
        if (op_reg[2]) begin
            step_hi = div_ok ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
            step_lo = {acc_lo_reg[XLEN-2:0], div_ok};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo_reg[XLEN-1:1]};
        end
    end

    // Sign fix-up and result selection once the iterations are exhausted
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_val;

    always_comb begin
        prod     = {acc_hi_reg, acc_lo_reg};
        prod_fix = neg_q_reg ? (~prod + 1'b1) : prod;
        quo_fix  = neg_q_reg ? (~acc_lo_reg + 1'b1) : acc_lo_reg;
        rem_fix  = neg_r_reg ? (~acc_hi_reg + 1'b1) : acc_hi_reg;
        if (special_reg)
            final_val = acc_lo_reg;
        else if (op_reg[2])
            final_val = op_reg[1] ? rem_fix : quo_fix;
        else if (op_reg == OP_MUL)
            final_val = prod_fix[XLEN-1:0];
        else
            final_val = prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (in_valid) state_next = S_CALC;
            S_CALC:  if (cnt_reg == '0) state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush)
            state_next = S_IDLE;
    end

    always_comb begin
        in_ready  = (state_reg == S_IDLE);
        out_valid = (state_reg == S_DONE);
        busy      = (state_reg != S_IDLE);
        result    = result_reg;
        zero      = zero_reg;
    end

    // Special results enter CALC with a zero count, so they finish one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg      <= '0;
            opnd_reg    <= '0;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= '0;
            cnt_reg     <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            special_reg <= 1'b0;
            result_reg  <= '0;
            zero_reg    <= 1'b0;
        end else if (!flush) begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        op_reg      <= mdu_ctrl;
                        special_reg <= special_in;
                        neg_q_reg   <= a_neg_in ^ b_neg_in;
                        neg_r_reg   <= a_neg_in;
                        acc_hi_reg  <= '0;
                        if (special_in) begin
                            opnd_reg   <= '0;
                            acc_lo_reg <= special_val_in;
                            cnt_reg    <= '0;
                        end else begin
                            opnd_reg   <= is_div_in ? b_mag_in : a_mag_in;
                            acc_lo_reg <= is_div_in ? a_mag_in : b_mag_in;
                            cnt_reg    <= CNT_W'(XLEN);
                        end
                    end
                end
                S_CALC: begin
                    if (cnt_reg != '0) begin
                        cnt_reg    <= cnt_reg - CNT_W'(1);
                        acc_hi_reg <= step_hi;
                        acc_lo_reg <= step_lo;
                    end else begin
                        result_reg <= final_val;
                        zero_reg   <= (final_val == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Randomized and directed bench for mdu_iterative against a plain-arithmetic
// reference of the RV64M multiply/divide semantics.
module tb_mdu_iterative;

    localparam int XLEN = 64;
    localparam logic [63:0] MIN_INT = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  mdu_ctrl = 3'b0;
    logic [63:0] rs1_data = '0;
    logic [63:0] rs2_data = '0;
    logic        in_ready, out_valid, zero, busy;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;
    logic [63:0] last_result = '0;

    mdu_iterative #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .mdu_ctrl(mdu_ctrl),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RV64M semantics from 128-bit products and language-level divide/modulo
    function automatic logic [63:0] ref_mdu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] sa, sb, ua, ub, p;
        logic signed [63:0] sa64, sb64, sq;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        ua = {64'b0, a};
        ub = {64'b0, b};
        sa64 = a;
        sb64 = b;
        p = '0;
        sq = '0;
        case (op)
            3'd0: begin p = ua * ub; return p[63:0]; end
            3'd1: begin p = sa * sb; return p[127:64]; end
            3'd2: begin p = sa * ub; return p[127:64]; end
            3'd3: begin p = ua * ub; return p[127:64]; end
            3'd4: begin
                if (b == 0) return ONES;
                if (a == MIN_INT && b == ONES) return MIN_INT;
                sq = sa64 / sb64;
                return sq;
            end
            3'd5: return (b == 0) ? ONES : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_INT && b == ONES) return 64'd0;
                sq = sa64 % sb64;
                return sq;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [63:0] pick();
        int sel;
        sel = $urandom_range(0, 5);
        case (sel)
            0: return 64'd0;
            1: return ONES;
            2: return MIN_INT;
            3: return 64'($urandom_range(0, 20));
            4: return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input string tag, input int hold);
        logic [63:0] exp;
        int lat;
        bit got, special;
        exp = ref_mdu(op, a, b);
        special = op[2] && (b == 0 || (!op[0] && a == MIN_INT && b == ONES));
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        mdu_ctrl = op;
        rs1_data = a;
        rs2_data = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rs1_data = {$urandom, $urandom};
        rs2_data = {$urandom, $urandom};
        mdu_ctrl = 3'($urandom);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            got = out_valid;
        end
        check({tag, "_valid"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(lat), special ? 64'd1 : 64'(XLEN + 1));
        check({tag, "_result"}, result, exp);
        check({tag, "_zero"}, 64'(zero), 64'(exp == 0));
        check({tag, "_busy_in_ready"}, {62'b0, busy, in_ready}, 64'b10);
        $display("op=%0d a=%h b=%h result=%h expected=%h latency=%0d", op, a, b, result, exp, lat);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_result"}, result, exp);
            check({tag, "_hold_flags"}, {61'b0, out_valid, in_ready, busy}, 64'b101);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_released"}, {62'b0, out_valid, in_ready}, 64'b01);
        last_result = exp;
    endtask

    task automatic start_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        mdu_ctrl = op;
        rs1_data = a;
        rs2_data = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, 64'd0);
        check("reset_flags", {60'b0, out_valid, in_ready, busy, zero}, 64'b0100);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd0, 64'd7, -64'd3, "mul_7_m3", 0);
        run_op(3'd3, ONES, ONES, "mulhu_ones", 0);
        run_op(3'd1, ONES, ONES, "mulh_ones", 0);
        run_op(3'd4, -64'd7, 64'd2, "div_m7_2", 0);
        run_op(3'd6, -64'd7, 64'd2, "rem_m7_2", 0);
        run_op(3'd7, 64'd7, 64'd7, "remu_7_7", 0);
        run_op(3'd5, 64'd5, 64'd0, "divu_by0", 0);
        run_op(3'd6, 64'd5, 64'd0, "rem_by0", 0);
        run_op(3'd4, MIN_INT, ONES, "div_ovf", 0);
        run_op(3'd6, MIN_INT, ONES, "rem_ovf", 0);
        run_op(3'd2, ONES, 64'd2, "mulhsu_m1_2", 0);
        run_op(3'd2, MIN_INT, ONES, "mulhsu_min", 0);
        run_op(3'd5, ONES, 64'd3, "divu_ones_3", 0);
        run_op(3'd0, 64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321, "mul_stall", 10);

        for (int i = 0; i < 40; i++)
            run_op(3'($urandom_range(0, 7)), pick(), pick(), "rand", 0);

        // Flush mid-CALC drops the op and keeps the old result
        start_op(3'd1, {$urandom, $urandom}, {$urandom, $urandom});
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_flags", {61'b0, out_valid, in_ready, busy}, 64'b010);
        check("flush_result", result, last_result);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen = 1'b1;
        end
        check("flush_quiet", 64'(seen), 64'd0);

        // Flush wins over a same-cycle handshake
        @(negedge clk);
        in_valid = 1'b1;
        flush = 1'b1;
        mdu_ctrl = 3'd5;
        rs1_data = 64'd9;
        rs2_data = 64'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush_handshake", {62'b0, busy, in_ready}, 64'b01);

        run_op(3'd0, 64'd11, 64'd13, "after_flush", 0);

        // Async reset mid-CALC
        start_op(3'd4, 64'd1000, 64'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_result", result, 64'd0);
        check("arst_flags", {60'b0, out_valid, in_ready, busy, zero}, 64'b0100);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd6, -64'd100, 64'd7, "after_reset", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
